// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides.
//   - FSM state encoding for the serial engines
//   - frame bit count (start + data + stop, parity excluded)
//   - parity helper
package uart_pkg;

  localparam int UART_STATE_W = 3;

  localparam logic [UART_STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [UART_STATE_W-1:0] ST_START  = 3'd1;
  localparam logic [UART_STATE_W-1:0] ST_DATA   = 3'd2;
  localparam logic [UART_STATE_W-1:0] ST_PARITY = 3'd3;
  localparam logic [UART_STATE_W-1:0] ST_STOP   = 3'd4;

  localparam int UART_DATA_BITS  = 8;
  // Start + 8 data + stop; an enabled parity bit adds one more.
  localparam int UART_FRAME_BITS = 10;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic uart_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write strobe and byte; ignored while full
//   pop, pop_data   read strobe; pop_data shows the head entry (show-ahead)
//   full, empty     occupancy flags derived from the registered count
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count, so a push while full is dropped
  // even when a pop happens on the same edge.
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serializer.
// Ports:
//   i_uart_clk, i_uart_rst_n  clock, asynchronous active-low reset
//   i_uart_tx_valid           write strobe for i_uart_tx_pdata
//   i_uart_tx_pdata           byte to transmit
//   o_uart_fifo_full          FIFO holds FIFO_DEPTH bytes
//   o_uart_tx_busy            FSM not idle or FIFO non-empty
//   o_uart_tx_sdata           registered serial line, idle high
//   o_uart_dbg_state          current FSM state (uart_pkg encoding)
//
// Handshake: i_uart_tx_valid / !o_uart_fifo_full act as a valid/ready pair.
// A byte transfers on a rising edge where valid=1 and full=0. Writes seen
// while full are dropped (not stalled); the writer must watch full itself.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 868,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0
) (
  input  logic                    i_uart_clk,
  input  logic                    i_uart_rst_n,
  input  logic                    i_uart_tx_valid,
  input  logic [7:0]              i_uart_tx_pdata,
  output logic                    o_uart_fifo_full,
  output logic                    o_uart_tx_busy,
  output logic                    o_uart_tx_sdata,
  output logic [UART_STATE_W-1:0] o_uart_dbg_state
);

  localparam int              TW        = $clog2(BAUD_DIV);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(BAUD_DIV - 1);

  logic [UART_STATE_W-1:0] state;
  logic [TW-1:0]           bit_timer;
  logic [2:0]              bit_idx;
  logic [7:0]              shift_reg;
  logic                    par_bit;
  logic                    bit_done;
  logic                    pop;
  logic                    fifo_empty;
  logic [7:0]              fifo_rd_data;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (i_uart_clk),
    .rst_n     (i_uart_rst_n),
    .push      (i_uart_tx_valid),
    .push_data (i_uart_tx_pdata),
    .pop       (pop),
    .pop_data  (fifo_rd_data),
    .full      (o_uart_fifo_full),
    .empty     (fifo_empty)
  );

  assign bit_done = (bit_timer == TIMER_MAX);

  // Pop when leaving IDLE, or at the end of STOP so frames run back to back.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && bit_done));

  assign o_uart_tx_busy   = (state != ST_IDLE) || !fifo_empty;
  assign o_uart_dbg_state = state;

  always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
    if (!i_uart_rst_n) begin
      state           <= ST_IDLE;
      bit_timer       <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      par_bit         <= 1'b0;
      o_uart_tx_sdata <= 1'b1;
    end else begin
      // The line is the registered image of the current state, so it trails
      // the FSM by one clock; every bit still lasts BAUD_DIV clocks.
      case (state)
        ST_START:  o_uart_tx_sdata <= 1'b0;
        ST_DATA:   o_uart_tx_sdata <= shift_reg[0];
        ST_PARITY: o_uart_tx_sdata <= par_bit;
        default:   o_uart_tx_sdata <= 1'b1;
      endcase

      if ((state == ST_IDLE) || bit_done) begin
        bit_timer <= '0;
      end else begin
        bit_timer <= bit_timer + TW'(1);
      end

      // The frame byte lives in shift_reg from the pop onwards, so later
      // FIFO writes cannot disturb it.
      if (pop) begin
        shift_reg <= fifo_rd_data;
        par_bit   <= uart_parity(fifo_rd_data, PAR_TYPE != 0);
      end

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_START;
        end
        ST_START: begin
          if (bit_done) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= (PAR_EN != 0) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) state <= ST_STOP;
        end
        ST_STOP: begin
          if (bit_done) state <= fifo_empty ? ST_IDLE : ST_START;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int BD = 4;
  localparam int FD = 4;

  // ---------------- clock / reset ----------------
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] pdata  = 8'h00;
  logic       valid0 = 1'b0;
  logic       valid1 = 1'b0;
  logic       valid2 = 1'b0;
  logic       full0, busy0, sd0;
  logic       full1, busy1, sd1;
  logic       full2, busy2, sd2;
  logic [2:0] st0, st1, st2;

  always #5 clk = ~clk;

  // dut: even parity, dut_odd: odd parity, dut_nopar: no parity bit
  uart_tx_engine #(.FIFO_DEPTH(FD), .BAUD_DIV(BD), .PAR_EN(1), .PAR_TYPE(0)) dut (
    .i_uart_clk(clk), .i_uart_rst_n(rst_n), .i_uart_tx_valid(valid0),
    .i_uart_tx_pdata(pdata), .o_uart_fifo_full(full0), .o_uart_tx_busy(busy0),
    .o_uart_tx_sdata(sd0), .o_uart_dbg_state(st0));

  uart_tx_engine #(.FIFO_DEPTH(FD), .BAUD_DIV(BD), .PAR_EN(1), .PAR_TYPE(1)) dut_odd (
    .i_uart_clk(clk), .i_uart_rst_n(rst_n), .i_uart_tx_valid(valid1),
    .i_uart_tx_pdata(pdata), .o_uart_fifo_full(full1), .o_uart_tx_busy(busy1),
    .o_uart_tx_sdata(sd1), .o_uart_dbg_state(st1));

  uart_tx_engine #(.FIFO_DEPTH(FD), .BAUD_DIV(BD), .PAR_EN(0), .PAR_TYPE(0)) dut_nopar (
    .i_uart_clk(clk), .i_uart_rst_n(rst_n), .i_uart_tx_valid(valid2),
    .i_uart_tx_pdata(pdata), .o_uart_fifo_full(full2), .o_uart_tx_busy(busy2),
    .o_uart_tx_sdata(sd2), .o_uart_dbg_state(st2));

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [0:0] exp_q[$];
  logic       got_q[$];
  logic       busy_q[$];
  logic       full_q[$];
  int         wr_k_q[$];
  logic [7:0] wr_d_q[$];

  function automatic logic line_of(input int sel);
    return (sel == 0) ? sd0 : (sel == 1) ? sd1 : sd2;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic logic full_of(input int sel);
    return (sel == 0) ? full0 : (sel == 1) ? full1 : full2;
  endfunction
  function automatic int par_en_of(input int sel);
    return (sel == 2) ? 0 : 1;
  endfunction
  function automatic int par_type_of(input int sel);
    return (sel == 1) ? 1 : 0;
  endfunction
  function automatic int frame_len(input int par_en);
    return (10 + par_en) * BD;
  endfunction

  // Reference line: two clocks of write-to-line latency, then each frame as
  // start 0, data LSB first, optional parity, stop 1, each bit BD clocks,
  // frames abutting, then idle high.
  task automatic model_line(input logic [7:0] bs[$], input int par_en,
                            input int par_type, input int n);
    logic bits[$];
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    foreach (bs[i]) begin
      bits.delete();
      bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) bits.push_back(bs[i][b]);
      if (par_en != 0)
        bits.push_back((($countones(bs[i]) % 2) == 1) ^ (par_type != 0));
      bits.push_back(1'b1);
      foreach (bits[j])
        for (int c = 0; c < BD; c++) exp_q.push_back(bits[j]);
    end
    while (exp_q.size() < n) exp_q.push_back(1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic sched_add(input int k, input logic [7:0] d);
    wr_k_q.push_back(k);
    wr_d_q.push_back(d);
  endtask

  task automatic drive_next(input int sel, input int k);
    logic v;
    v = 1'b0;
    if (wr_k_q.size() > 0 && wr_k_q[0] == k) begin
      pdata = wr_d_q[0];
      v = 1'b1;
      void'(wr_k_q.pop_front());
      void'(wr_d_q.pop_front());
    end
    valid0 = v && (sel == 0);
    valid1 = v && (sel == 1);
    valid2 = v && (sel == 2);
  endtask

  // Sample k is taken at the falling edge after rising edge N+k, where edge N
  // is the one that sees the write scheduled at k=0.
  task automatic run_sched(input int sel, input int n);
    got_q.delete();
    busy_q.delete();
    full_q.delete();
    @(negedge clk);
    drive_next(sel, 0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      got_q.push_back(line_of(sel));
      busy_q.push_back(busy_of(sel));
      full_q.push_back(full_of(sel));
      drive_next(sel, k + 1);
    end
    wr_k_q.delete();
    wr_d_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    pdata  = 8'hAA;
    valid0 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (line_of(s) !== 1'b1) begin
        errors++; $display("FAIL reset_line[%0d]: got %b want 1", s, line_of(s));
      end
      checks++;
      if (busy_of(s) !== 1'b0) begin
        errors++; $display("FAIL reset_busy[%0d]: got %b want 0", s, busy_of(s));
      end
      checks++;
      if (full_of(s) !== 1'b0) begin
        errors++; $display("FAIL reset_full[%0d]: got %b want 0", s, full_of(s));
      end
    end
    valid0 = 1'b0;
    rst_n  = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_no_write: busy got %b want 0", busy0);
    end
    checks++;
    if (st0 !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", st0, ST_IDLE);
    end
  endtask

  task automatic test_single();
    int n;
    int last;
    n    = 2 + frame_len(1) + 3;
    last = 1 + frame_len(1);
    sched_add(0, 8'h55);
    model_line('{8'h55}, 1, 0, n);
    run_sched(0, n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL single line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
    // busy comes from the FSM, which leads the registered line by a clock
    checks++;
    if (busy_q[last-1] !== 1'b1) begin
      errors++; $display("FAIL single busy_in_frame: got %b want 1", busy_q[last-1]);
    end
    checks++;
    if (busy_q[last] !== 1'b0) begin
      errors++; $display("FAIL single busy_drop: got %b want 0", busy_q[last]);
    end
  endtask

  task automatic test_parity_odd();
    int n;
    n = 2 + frame_len(1) + 3;
    sched_add(0, 8'h01);
    model_line('{8'h01}, 1, 1, n);
    run_sched(1, n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL odd line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
    // parity bit of 0x01 with odd parity is 0
    checks++;
    if (got_q[2 + 9*BD + 1] !== 1'b0) begin
      errors++; $display("FAIL odd parity_bit: got %b want 0", got_q[2 + 9*BD + 1]);
    end
  endtask

  task automatic test_no_parity();
    int n;
    int last;
    n    = 2 + frame_len(0) + 3;
    last = 1 + frame_len(0);
    sched_add(0, 8'h01);
    model_line('{8'h01}, 0, 0, n);
    run_sched(2, n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL nopar line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (busy_q[last-1] !== 1'b1 || busy_q[last] !== 1'b0) begin
      errors++; $display("FAIL nopar frame_len: busy got %b%b want 10",
                         busy_q[last-1], busy_q[last]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int last;
    n    = 2 + 3*frame_len(1) + 3;
    last = 1 + 3*frame_len(1);
    sched_add(0, 8'hA1);
    sched_add(1, 8'hB2);
    sched_add(2, 8'hC3);
    model_line('{8'hA1, 8'hB2, 8'hC3}, 1, 0, n);
    run_sched(0, n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL b2b line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
    checks++;
    if (busy_q[last-1] !== 1'b1 || busy_q[last] !== 1'b0) begin
      errors++; $display("FAIL b2b busy_end: got %b%b want 10", busy_q[last-1], busy_q[last]);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bs[$];
    logic [7:0] sent[$];
    int n;
    for (int i = 0; i < 6; i++) begin
      bs.push_back(8'($urandom_range(0, 255)));
      sched_add(i, bs[i]);
    end
    // one byte in flight plus FD queued are accepted; the sixth is dropped
    for (int i = 0; i < 1 + FD; i++) sent.push_back(bs[i]);
    n = 2 + 5*frame_len(1) + 3;
    model_line(sent, 1, 0, n);
    run_sched(0, n);
    checks++;
    if (full_q[3] !== 1'b0) begin
      errors++; $display("FAIL full_before_5th: got %b want 0", full_q[3]);
    end
    checks++;
    if (full_q[4] !== 1'b1) begin
      errors++; $display("FAIL full_after_5th: got %b want 1", full_q[4]);
    end
    checks++;
    if (full_q[5] !== 1'b1) begin
      errors++; $display("FAIL full_after_drop: got %b want 1", full_q[5]);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL full line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_write_on_pop();
    logic [7:0] bs[$];
    logic [7:0] extra;
    int n;
    int pop_k;
    for (int i = 0; i < 5; i++) begin
      bs.push_back(8'($urandom_range(0, 255)));
      sched_add(i, bs[i]);
    end
    // first frame started at edge N+1; the next pop is when it ends
    pop_k = 1 + frame_len(1);
    extra = 8'($urandom_range(0, 255));
    sched_add(pop_k, 8'h3C);
    sched_add(pop_k + 1, extra);
    bs.push_back(extra);
    n = 2 + 6*frame_len(1) + 3;
    model_line(bs, 1, 0, n);
    run_sched(0, n);
    checks++;
    if (full_q[pop_k-1] !== 1'b1) begin
      errors++; $display("FAIL wpop full_before: got %b want 1", full_q[pop_k-1]);
    end
    checks++;
    if (full_q[pop_k] !== 1'b0) begin
      errors++; $display("FAIL wpop dropped_count: full got %b want 0", full_q[pop_k]);
    end
    checks++;
    if (full_q[pop_k+1] !== 1'b1) begin
      errors++; $display("FAIL wpop refill: full got %b want 1", full_q[pop_k+1]);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL wpop line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] nb;
    int n;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    sched_add(0, 8'hF0);
    sched_add(1, b1);
    sched_add(2, b2);
    model_line('{8'hF0, b1, b2}, 1, 0, 16);
    run_sched(0, 16);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rstmid pre line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sd0 !== 1'b1) begin
      errors++; $display("FAIL rstmid line_async: got %b want 1", sd0);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL rstmid busy: got %b want 0", busy0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sched(0, 60);
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (got_q[k] !== 1'b1 || busy_q[k] !== 1'b0) begin
        errors++; $display("FAIL rstmid after[%0d]: line %b busy %b want 1 0",
                           k, got_q[k], busy_q[k]);
      end
    end
    nb = 8'($urandom_range(0, 255));
    n  = 2 + frame_len(1) + 3;
    sched_add(0, nb);
    model_line('{nb}, 1, 0, n);
    run_sched(0, n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL rstmid new line[%0d]: got %b want %b", k, got_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] bs[$];
    int sel;
    int cnt;
    int n;
    for (int it = 0; it < 6; it++) begin
      sel = $urandom_range(0, 2);
      cnt = $urandom_range(1, 4);
      bs.delete();
      for (int i = 0; i < cnt; i++) begin
        bs.push_back(8'($urandom_range(0, 255)));
        sched_add(i, bs[i]);
      end
      n = 2 + cnt*frame_len(par_en_of(sel)) + 3;
      model_line(bs, par_en_of(sel), par_type_of(sel), n);
      run_sched(sel, n);
      for (int k = 0; k < n; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL random it%0d dut%0d line[%0d]: got %b want %b",
                             it, sel, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_parity_odd();
    test_no_parity();
    test_back_to_back();
    test_fifo_full();
    test_write_on_pop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: TX FIFO entries, a power of two, minimum 2.
REQ-002 SHALL have parameter BAUD_DIV, default 868: clocks per serial bit, minimum 2.
REQ-003 SHALL have parameter PAR_EN, default 1: 1 = parity bit present.
REQ-004 SHALL have parameter PAR_TYPE, default 0: 0 = even parity, 1 = odd parity.
REQ-005 SHALL have port i_uart_clk  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_uart_rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_uart_tx_valid  input  1  core write strobe for one byte.
REQ-008 SHALL have port i_uart_tx_pdata  input  8  byte to transmit.
REQ-009 SHALL have port o_uart_fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 SHALL have port o_uart_tx_busy  output  1  FSM not IDLE, or FIFO non-empty.
REQ-011 SHALL have port o_uart_tx_sdata  output  1  serial line, idle high.

Function
REQ-012 SHALL accept a byte on each clock where i_uart_tx_valid=1 and o_uart_fifo_full=0; a write while full SHALL be dropped with no state change.
REQ-013 SHALL compute full from the registered count, so a write while full is dropped even if a pop occurs in the same cycle.
REQ-014 SHALL keep the count unchanged on a simultaneous accepted write and pop.
REQ-015 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL transition from IDLE to START, popping one byte, when the FIFO is non-empty.
REQ-018 SHALL hold each state for exactly BAUD_DIV clocks, timed by a bit-timer counting 0..BAUD_DIV-1.
REQ-019 SHALL drive o_uart_tx_sdata = 0 in START.
REQ-020 SHALL send 8 data bits LSB first in DATA, using a 3-bit bit index.
REQ-021 SHALL drive, in PARITY, the XOR of the 8 bits for PAR_TYPE=0, or its inverse for PAR_TYPE=1.
REQ-022 SHALL skip PARITY when PAR_EN=0, going DATA to STOP.
REQ-023 SHALL drive o_uart_tx_sdata = 1 in STOP and IDLE.
REQ-024 SHALL go from the end of STOP directly to START with a pop when the FIFO is non-empty, with no idle bit between frames; otherwise to IDLE.
REQ-025 SHALL produce a frame of (10+PAR_EN)*BAUD_DIV clocks.
REQ-026 SHALL register o_uart_tx_sdata.
REQ-027 SHALL have latency such that a byte accepted at edge N into an empty FIFO with an IDLE FSM makes the line fall at edge N+2.
REQ-028 SHALL latch the byte being sent in a shift register at pop, so FIFO writes never corrupt an in-flight frame.

Reset
REQ-029 SHALL, when i_uart_rst_n=0 and asynchronously: o_uart_tx_sdata=1, o_uart_fifo_full=0, o_uart_tx_busy=0, FSM=IDLE, pointers/count/bit-timer/bit index=0.
REQ-030 SHALL, on reset mid-frame, abort the frame, return the line high immediately and discard FIFO contents.
REQ-031 SHALL accept no write in the first clock after reset release only if valid is sampled while reset is still asserted; the normal rule applies from the first edge with reset high.

Structure
REQ-032 SHALL place the FSM state encoding and a UART frame-bit-count constant in the shared uart package used by the RX side.
REQ-033 SHALL instantiate one sub-module, uart_tx_fifo (synchronous FIFO with push, pop, full, empty); the FSM and bit-timer remain in uart_tx_engine.

Verification (BAUD_DIV=4, FIFO_DEPTH=4, PAR_EN=1, PAR_TYPE=0 unless stated)
REQ-034 SHALL verify: write 0x55 once -> line low at N+2; bits 1,0,1,0,1,0,1,0; parity 0; stop 1; 44 clocks; busy drops after stop.
REQ-035 SHALL verify: PAR_TYPE=1, write 0x01 -> parity bit 0; PAR_EN=0, write 0x01 -> 40-clock frame, no parity.
REQ-036 SHALL verify: write 0xA1, 0xB2, 0xC3 on consecutive clocks -> three back-to-back frames, 132 clocks, no idle gap, bytes in order.
REQ-037 SHALL verify: 6 consecutive writes while the first frame is active -> full asserts after the 5th accepted byte (1 in flight + 4 queued); 6th dropped; exactly 5 frames sent.
REQ-038 SHALL verify: reset asserted mid-DATA of 0xF0 with 2 queued bytes -> line 1 same cycle, busy 0, no frame after release until a new write.
REQ-039 SHALL verify: write 0x3C in the same cycle as a pop from a full FIFO -> write dropped, count decremented by 1.
